// File: rtl/scram_pkg.sv
// Shared constants and FSM state type for the
// 802.11 x^7+x^4+1 scrambler/descrambler blocks.
package scram_pkg;

  localparam int LFSR_W       = 7;
  localparam int TAP_HI       = 6;
  localparam int TAP_LO       = 3;
  localparam int SEED_BITS    = 7;
  localparam int SERVICE_BITS = 16;
  localparam int TAIL_BITS    = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_SERVICE,
    S_PSDU,
    S_TAIL,
    S_PAD,
    S_DONE
  } state_e;

endpackage

// File: rtl/descramble_ctrl_if.sv
// Serial bit stream with valid/ready handshake.
// master drives valid/data/last, slave drives ready.
interface descramble_ctrl_if;

  logic valid;
  logic data;
  logic last;
  logic ready;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/scram_lfsr.sv
// x^7+x^4+1 LFSR core: serial seed load or step.
// Ports: load_en, step_en, in_bit -> d, state.
module scram_lfsr
  import scram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              step_en,
  input  logic              in_bit,
  output logic              d,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] s_q;
  logic [LFSR_W-1:0] s_d;
  logic              f;

  assign f     = s_q[TAP_HI] ^ s_q[TAP_LO];
  assign d     = in_bit ^ f;
  assign state = s_q;

  always_comb begin
    s_d = s_q;
    if (load_en) begin
      s_d = {s_q[LFSR_W-2:0], in_bit};
    end else if (step_en) begin
      s_d = {s_q[LFSR_W-2:0], f};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/descramble_ctrl.sv
// RX DATA-field descrambler sequencer: seed, SERVICE check,
// PSDU out (in_s -> out_m), tail/pad drop; status ports.
module descramble_ctrl
  import scram_pkg::*;
#(
  parameter int LEN_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  descramble_ctrl_if.slave  in_s,
  descramble_ctrl_if.master out_m,
  output logic              busy,
  output logic              done,
  output logic              service_err,
  output logic              seed_err,
  output logic              trunc_err
);

  localparam int CNT_W = LEN_W + 3;
  localparam logic [CNT_W-1:0] SEED_END =
    CNT_W'(SEED_BITS - 1);
  localparam logic [CNT_W-1:0] CHK_END =
    CNT_W'(SERVICE_BITS - SEED_BITS - 1);
  localparam logic [CNT_W-1:0] TAIL_END =
    CNT_W'(TAIL_BITS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ov_q, ov_d;
  logic              ob_q, ob_d;
  logic              ol_q, ol_d;
  logic              serr_q, serr_d;
  logic              sderr_q, sderr_d;
  logic              terr_q, terr_d;
  logic              chk_q, chk_d;

  logic              ld;
  logic              st;
  logic              d;
  logic              rdy;
  logic              xfer;
  logic              last;
  logic              psdu_end;
  logic [LFSR_W-1:0] s;

  scram_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (reset),
    .load_en (ld),
    .step_en (st),
    .in_bit  (in_s.data),
    .d       (d),
    .state   (s)
  );

  // PSDU accepts only when the output slot frees up
  assign rdy =
    (state_q inside {S_SEED, S_SERVICE, S_TAIL, S_PAD}) ||
    (state_q == S_PSDU && (!ov_q || out_m.ready));

  assign xfer     = in_s.valid & rdy;
  assign last     = in_s.last;
  assign psdu_end =
    (cnt_q == ({len_q, 3'b000} - CNT_W'(1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ov_d    = ov_q;
    ob_d    = ob_q;
    ol_d    = ol_q;
    serr_d  = serr_q;
    sderr_d = sderr_q;
    terr_d  = terr_q;
    chk_d   = 1'b0;
    ld      = 1'b0;
    st      = 1'b0;
    done    = 1'b0;

    if (ov_q && out_m.ready) begin
      ov_d = 1'b0;
    end

    // seed is complete one cycle after the 7th load
    if (chk_q && s == '0) begin
      sderr_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEED;
          cnt_d   = '0;
          len_d   = length;
          serr_d  = 1'b0;
          sderr_d = 1'b0;
          terr_d  = 1'b0;
        end
      end
      S_SEED: begin
        if (xfer) begin
          ld    = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == SEED_END) begin
            chk_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_SERVICE;
          end
          if (last) begin
            terr_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_SERVICE: begin
        if (xfer) begin
          st    = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (d) begin
            serr_d = 1'b1;
          end
          if (cnt_q == CHK_END) begin
            cnt_d   = '0;
            state_d = (len_q == '0) ? S_TAIL : S_PSDU;
          end
          if (last) begin
            terr_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_PSDU: begin
        if (xfer) begin
          st    = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          ov_d  = 1'b1;
          ob_d  = d;
          ol_d  = psdu_end | last;
          if (psdu_end) begin
            cnt_d   = '0;
            state_d = S_TAIL;
          end
          if (last) begin
            terr_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_TAIL: begin
        if (xfer) begin
          st    = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == TAIL_END) begin
            cnt_d   = '0;
            state_d = last ? S_DONE : S_PAD;
          end else if (last) begin
            terr_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_PAD: begin
        if (xfer) begin
          st = 1'b1;
          if (last) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!ov_q && !chk_q) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      ov_q    <= 1'b0;
      ob_q    <= 1'b0;
      ol_q    <= 1'b0;
      serr_q  <= 1'b0;
      sderr_q <= 1'b0;
      terr_q  <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ov_q    <= ov_d;
      ob_q    <= ob_d;
      ol_q    <= ol_d;
      serr_q  <= serr_d;
      sderr_q <= sderr_d;
      terr_q  <= terr_d;
      chk_q   <= chk_d;
    end
  end

  assign in_s.ready  = rdy;
  assign out_m.valid = ov_q;
  assign out_m.data  = ob_q;
  assign out_m.last  = ol_q;
  assign busy        = (state_q != S_IDLE);
  assign service_err = serr_q;
  assign seed_err    = sderr_q;
  assign trunc_err   = terr_q;

endmodule

// File: tb/tb_descramble_ctrl.sv
// Self-checking bench for descramble_ctrl with a
// sequence-level TX scrambler model and scoreboard.
module tb_descramble_ctrl;
  import scram_pkg::*;

  localparam int LEN_W = 12;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] length = '0;
  logic             busy;
  logic             done;
  logic             service_err;
  logic             seed_err;
  logic             trunc_err;

  descramble_ctrl_if in_if ();
  descramble_ctrl_if out_if ();

  descramble_ctrl #(.LEN_W(LEN_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .length      (length),
    .in_s        (in_if),
    .out_m       (out_if),
    .busy        (busy),
    .done        (done),
    .service_err (service_err),
    .seed_err    (seed_err),
    .trunc_err   (trunc_err)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  byte unsigned psdu[$];
  bit  wire_q[$];
  bit  exp_q[$];
  int  exp_n;
  bit  e_serr, e_sderr, e_terr;
  bit  rnd_ready;
  bit  frame_end;
  int  cyc, last_xfer_cyc, done_cnt;
  int  ov_cycles, out_n;
  bit  held_v, held_b;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // TX side: data = 16 zero SERVICE bits, PSDU LSB
  // first, 6 zero tail bits, random pad. Keystream
  // z[n] = z[n-7] ^ z[n-4], seeded by 7 prior values.
  task automatic build(input bit [6:0] seed,
                       input int len, input int flip,
                       input int cut, input int npad);
    bit data[$];
    bit zz[];
    int n;
    int pend;
    data = {};
    for (int i = 0; i < 16; i++) data.push_back(1'b0);
    for (int i = 0; i < len; i++)
      for (int b = 0; b < 8; b++)
        data.push_back(psdu[i][b]);
    for (int i = 0; i < 6; i++) data.push_back(1'b0);
    for (int i = 0; i < npad; i++)
      data.push_back(1'($urandom_range(0, 1)));
    n = data.size();
    if (cut >= 0 && cut < n) n = cut + 1;
    zz = new[n + 7];
    for (int i = 0; i < 7; i++) zz[i] = seed[6 - i];
    for (int k = 7; k < n + 7; k++)
      zz[k] = zz[k - 7] ^ zz[k - 4];
    wire_q = {};
    for (int i = 0; i < n; i++)
      wire_q.push_back(data[i] ^ zz[i + 7] ^ (i == flip));
    exp_q = {};
    pend = 16 + 8 * len;
    for (int i = 16; i < n && i < pend; i++)
      exp_q.push_back(data[i]);
    exp_n   = exp_q.size();
    e_serr  = (flip >= 7 && flip < 16 && flip < n);
    e_sderr = (seed == 7'd0);
    e_terr  = (n < pend + 6);
  endtask

  task automatic drive(input int limit, input bit gaps,
                       input int ign_at);
    int n;
    int w;
    n = wire_q.size();
    for (int i = 0; i < n && i < limit; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_if.valid = 1'b0;
        @(posedge clk); #1;
      end
      in_if.valid = 1'b1;
      in_if.data  = wire_q[i];
      in_if.last  = (i == n - 1);
      if (i == ign_at) begin
        start  = 1'b1;
        length = LEN_W'(1);
      end
      w = 0;
      @(negedge clk);
      while (!in_if.ready && w < 100) begin
        w++;
        @(negedge clk);
      end
      if (w >= 100) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_if.valid = 1'b0;
    in_if.last  = 1'b0;
  endtask

  task automatic mon_step();
    bit eb;
    cyc++;
    if (held_v) begin
      chk("hold_valid", out_if.valid, 1);
      chk("hold_bit", out_if.data, held_b);
    end
    held_v = 1'b0;
    if (out_if.valid) begin
      ov_cycles++;
      if (out_if.ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_out", 1, 0);
        end else begin
          eb = exp_q.pop_front();
          chk("out_bit", out_if.data, eb);
          chk("out_last", out_if.last,
              exp_q.size() == 0);
        end
        out_n++;
        last_xfer_cyc = cyc;
      end else begin
        held_v = 1'b1;
        held_b = out_if.data;
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_after_out", cyc > last_xfer_cyc, 1);
    end
  endtask

  task automatic run_frame(input bit [6:0] seed,
                           input int len, input int flip,
                           input int cut, input int npad,
                           input bit rnd, input bit gaps,
                           input int ign_at,
                           input int abort_at);
    int w;
    build(seed, len, flip, cut, npad);
    rnd_ready     = rnd;
    frame_end     = 1'b0;
    cyc           = 0;
    last_xfer_cyc = -1;
    done_cnt      = 0;
    ov_cycles     = 0;
    out_n         = 0;
    held_v        = 1'b0;
    @(posedge clk); #1;
    start  = 1'b1;
    length = LEN_W'(len);
    @(posedge clk); #1;
    start  = 1'b0;
    length = LEN_W'($urandom);
    chk("busy_after_start", busy, 1);
    fork
      begin
        if (abort_at >= 0) begin
          drive(abort_at, gaps, -1);
        end else begin
          drive(wire_q.size(), gaps, ign_at);
          w = 0;
          while (done_cnt == 0 && w < 400) begin
            @(negedge clk);
            w++;
          end
          chk("done_seen", done_cnt > 0, 1);
        end
        frame_end = 1'b1;
      end
      begin
        while (!frame_end) begin
          out_if.ready = rnd_ready ?
            1'($urandom_range(0, 1)) : 1'b1;
          @(posedge clk); #1;
        end
        out_if.ready = 1'b1;
      end
      begin
        while (!frame_end) begin
          @(negedge clk);
          mon_step();
        end
      end
    join
    if (abort_at < 0) begin
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
      chk("out_count", out_n, exp_n);
      chk("exp_drained", exp_q.size(), 0);
      chk("service_err", service_err, e_serr);
      chk("seed_err", seed_err, e_sderr);
      chk("trunc_err", trunc_err, e_terr);
    end
  endtask

  task automatic rand_psdu(input int len);
    psdu = {};
    for (int i = 0; i < len; i++)
      psdu.push_back(8'($urandom));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_if.ready, 0);
    chk({tag, "_out_valid"}, out_if.valid, 0);
    chk({tag, "_out_bit"}, out_if.data, 0);
    chk({tag, "_out_last"}, out_if.last, 0);
    chk({tag, "_service_err"}, service_err, 0);
    chk({tag, "_seed_err"}, seed_err, 0);
    chk({tag, "_trunc_err"}, trunc_err, 0);
  endtask

  initial begin
    in_if.valid  = 1'b0;
    in_if.data   = 1'b0;
    in_if.last   = 1'b0;
    out_if.ready = 1'b1;

    #12;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // known frame: 0xA5 0x3C, seed all ones
    psdu = {8'hA5, 8'h3C};
    run_frame(7'h7F, 2, -1, -1, 10, 0, 0, -1, -1);

    // empty PSDU
    run_frame(7'h5B, 0, -1, -1, 10, 0, 1, -1, -1);
    chk("len0_no_out_valid", ov_cycles, 0);

    // long frame, random backpressure, stalls,
    // start pulse while busy
    rand_psdu(100);
    run_frame(7'($urandom_range(1, 127)), 100, -1, -1,
              13, 1, 1, 300, -1);

    // SERVICE bit 12 flipped on the wire
    rand_psdu(3);
    run_frame(7'h2D, 3, 12, -1, 4, 1, 0, -1, -1);

    // zero seed
    rand_psdu(2);
    run_frame(7'h00, 2, -1, -1, 6, 0, 0, -1, -1);

    // in_last on 5th PSDU bit of a 4-byte frame
    rand_psdu(4);
    run_frame(7'h11, 4, -1, 16 + 4, 8, 0, 0, -1, -1);
    chk("trunc_psdu_5_bits", out_n, 5);

    // in_last on 3rd tail bit, random backpressure
    rand_psdu(3);
    run_frame(7'h6A, 3, -1, 16 + 24 + 2, 8, 1, 0, -1, -1);

    // reset mid-PSDU
    rand_psdu(6);
    run_frame(7'h33, 6, -1, -1, 8, 1, 0, -1, 16 + 20);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk_all_zero("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    reset = 1'b1;

    // fresh frame after the abort
    rand_psdu(5);
    run_frame(7'($urandom_range(1, 127)), 5, -1, -1,
              7, 1, 1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/descramble_ctrl.md
# descramble_ctrl

Receive-side sequencer for the 802.11a/g DATA field descrambler. It recovers the scrambler seed from the first 7 SERVICE bits, checks the remaining 9 SERVICE bits, and descrambles exactly 8×LENGTH PSDU bits onto an output stream with backpressure. Tail and pad bits are dropped. It sits between the deinterleaver/Viterbi bit stream and the MAC byte packer, and owns the x^7+x^4+1 LFSR through a small core sub-module.

## Interface
- LEN_W, 12: width of PSDU LENGTH in bytes (802.11 L-SIG LENGTH).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse in IDLE; latches `length`.
- length  in  LEN_W  PSDU length in bytes; 0 is legal.
- in_valid  in  1  input bit qualifier.
- in_bit  in  1  scrambled bit, in air order.
- in_last  in  1  marks the final bit of the DATA field (end of pad).
- in_ready  out  1  controller accepts `in_bit` this cycle.
- out_valid  out  1  descrambled PSDU bit valid.
- out_bit  out  1  descrambled PSDU bit.
- out_last  out  1  with the final PSDU bit.
- out_ready  in  1  downstream accepts.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the frame finishes (normally or on error).
- service_err  out  1  sticky until next start; a descrambled SERVICE bit 7..15 was 1.
- seed_err  out  1  sticky until next start; recovered seed = 7'b0.
- trunc_err  out  1  sticky until next start; in_last arrived before TAIL completed.

## Operation
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- LFSR state s[6:0]. Feedback is f = s[6]^s[3].
  - Seed load: s <= {s[5:0], in_bit}.
  - Descramble: d = in_bit^f; s <= {s[5:0], f}.
- FSM states: IDLE, SEED, SERVICE, PSDU, TAIL, PAD, DONE.
  - IDLE: when start, clear errors, latch length, and go to SEED. start in any other state is ignored.
  - SEED: accept 7 bits with seed load. After the 7th bit, go to SERVICE; set seed_err if s == 0.
  - SERVICE: accept 9 bits with descramble. Any d = 1 sets service_err. After the 9th bit, go to PSDU, or to TAIL if length == 0.
  - PSDU: accept 8×length bits with descramble and drive d on the output. After the last bit, go to TAIL.
  - TAIL: accept 6 bits with descramble and discard them. After the 6th bit, go to DONE if in_last is set on that bit, else to PAD.
  - PAD: discard bits (LFSR still advances) until in_last, then go to DONE.
  - DONE: pulse done for one cycle, then go to IDLE.
- in_last in SEED, SERVICE, PSDU, or TAIL before the 6th tail bit:
  - set trunc_err and go to DONE;
  - any PSDU bit already registered on the output is still delivered, with out_last forced on it.
- in_ready:
  - 1 in SEED, SERVICE, TAIL and PAD;
  - 1 in PSDU when the output register is empty or out_ready = 1;
  - 0 in IDLE and DONE.
- Bit counter is LEN_W+3 bits wide with no overflow; length = 4095 gives 32760 PSDU bits.

## Timing
- Output is registered, with 1-cycle latency from the input transfer to out_valid.
- out_bit is held stable while out_valid & !out_ready.
- At most one bit is in flight. The FSM leaves PSDU only after the final bit has been accepted at the input. TAIL bits may be accepted while the last PSDU bit is stalled on the output.
- done asserts no earlier than the cycle after the last output transfer.
- Reset values: all outputs 0, state IDLE, s = 0, counters 0.
- Reset mid-frame aborts immediately with no done pulse.
- in_valid = 0 stalls every state with no state change.

## Structure
- Shared package scram_pkg holds:
  - LFSR_W = 7 and tap constants 6 and 3;
  - SEED_BITS = 7, SERVICE_BITS = 16, TAIL_BITS = 6;
  - the state enum.
- Sub-module scram_lfsr:
  - inputs load_en, step_en, in_bit;
  - outputs d and state;
  - shared with the TX scrambler controller.
- descramble_ctrl contains the FSM, the counter, the output register and the error flags.

## Test plan
- Seed 7'b1111111, length = 2, PSDU 0xA5 0x3C (LSB first), TX-scrambled, then 6 tail bits and 10 pad bits, then in_last → out bits exactly 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; out_last on the 16th bit; done 1 cycle later; no errors.
- length = 0 → zero out_valid cycles; done after the tail and pad bits.
- Random out_ready (50%) over a 100-byte frame → in-order output with no loss or duplication; out_bit stable during stalls.
- Flip SERVICE bit 12 on the wire → service_err = 1, PSDU still correct. Seed bits all 0 → seed_err = 1.
- in_last on PSDU bit 5 of a 4-byte frame → 5 output bits, out_last on the 5th, trunc_err = 1, done pulses, back in IDLE.
- Assert reset low mid-PSDU → all outputs 0 asynchronously, no done; a following start decodes a new frame correctly.
